onchip_mem_arbiter: RTL

Two-master round-robin arbiter that shares the single-port 32-bit on-chip instruction/data RAM (13-bit word address, 4 byte lanes, 1-cycle read latency) between the Nios II data master and a second Avalon-MM master (DMA/debug). It sits between the interconnect and the RAM's slave port. It grants one access per cycle, routes read data back with a tracked-owner pipeline stage, and traps accesses beyond the populated depth.

---
 rtl/onchip_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin sharing of the single-port on-chip RAM
// between two Avalon-MM masters, with read-owner tracking and range trap.
module onchip_mem_arbiter #(
    parameter int DEPTH = 6049,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,
    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic [31:0]   mem_writedata,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic          err_flag,
    output logic [AW-1:0] err_addr,
    output logic          err_master,
    input  logic          err_clear
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic          req0, req1;
    logic          gnt0, gnt1, gnt;
    logic [AW-1:0] g_addr;
    logic [3:0]    g_be;
    logic [31:0]   g_wdata;
    logic          g_wr;
    logic          in_range;

    logic          last_q, last_d;
    logic          ready_q, ready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;
    logic          rd_oor_q, rd_oor_d;
    logic          err_flag_q, err_flag_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic          err_master_q, err_master_d;

    // Grant: lone requester wins; on contention the master not granted last wins.
    // Nothing is accepted until the first clock after reset release.
    always_comb begin
        req0     = m0_read | m0_write;
        req1     = m1_read | m1_write;
        gnt0     = ready_q & req0 & (~req1 | last_q);
        gnt1     = ready_q & req1 & (~req0 | ~last_q);
        gnt      = gnt0 | gnt1;
        g_addr   = gnt1 ? m1_address    : m0_address;
        g_be     = gnt1 ? m1_byteenable : m0_byteenable;
        g_wdata  = gnt1 ? m1_writedata  : m0_writedata;
        g_wr     = gnt1 ? m1_write      : m0_write;
        in_range = {1'b0, g_addr} < LIMIT;
    end

    // RAM port drive: idle cycles replay the last granted address/lanes/data.
    always_comb begin
        mem_chipselect = gnt & in_range;
        mem_write      = gnt & in_range & g_wr;
        mem_address    = gnt ? g_addr  : addr_q;
        mem_byteenable = gnt ? g_be    : be_q;
        mem_writedata  = gnt ? g_wdata : wdata_q;
        mem_clken      = reset_n;
    end

    // Master-side handshake and read return, steered by the tracked owner.
    always_comb begin
        m0_waitrequest   = reset_n & req0 & ~gnt0;
        m1_waitrequest   = reset_n & req1 & ~gnt1;
        m0_readdatavalid = rd_pend_q & ~rd_owner_q;
        m1_readdatavalid = rd_pend_q & rd_owner_q;
        m0_readdata      = (m0_readdatavalid & ~rd_oor_q) ? mem_readdata : '0;
        m1_readdata      = (m1_readdatavalid & ~rd_oor_q) ? mem_readdata : '0;
        err_flag         = err_flag_q;
        err_addr         = err_addr_q;
        err_master       = err_master_q;
    end

    // Next state: fairness pointer, held port values, read tracking, error capture.
    always_comb begin
        last_d       = last_q;
        ready_d      = 1'b1;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_pend_d    = gnt & ~g_wr;
        rd_owner_d   = gnt1;
        rd_oor_d     = ~in_range;
        err_flag_d   = err_flag_q;
        err_addr_d   = err_addr_q;
        err_master_d = err_master_q;
        if (gnt) begin
            last_d  = gnt1;
            addr_d  = g_addr;
            be_d    = g_be;
            wdata_d = g_wdata;
        end
        if (err_clear) begin
            err_flag_d   = 1'b0;
            err_addr_d   = '0;
            err_master_d = 1'b0;
        end else if (gnt & ~in_range & ~err_flag_q) begin
            err_flag_d   = 1'b1;
            err_addr_d   = g_addr;
            err_master_d = gnt1;
        end
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q       <= 1'b1;
            ready_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
            err_flag_q   <= 1'b0;
            err_addr_q   <= '0;
            err_master_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            ready_q      <= ready_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
            err_flag_q   <= err_flag_d;
            err_addr_q   <= err_addr_d;
            err_master_q <= err_master_d;
        end
    end

endmodule
